// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone burst responder.
// Holds the FSM state encoding, bus field widths and the beat-count rule.
package wb_pkg;

    localparam int WB_DATA_LEN = 32;
    localparam int WB_BL_LEN   = 10;
    localparam int WB_SEL_LEN  = 4;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        XFER,
        ERR,
        DONE
    } wb_state_e;

    // A zero burst length still moves one word.
    function automatic logic [WB_BL_LEN-1:0] wb_beats(input logic [WB_BL_LEN-1:0] bl);
        return (bl == '0) ? WB_BL_LEN'(1) : bl;
    endfunction

endpackage

// File: rtl/wb_resp_mem.sv
// Single-port word array with byte-lane write enables and a registered read port.
// The read register doubles as the responder's data output, so it is reset.
module wb_resp_mem
    import wb_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   en,
    input  logic                   we,
    input  logic [WB_SEL_LEN-1:0]  be,
    input  logic [AW-1:0]          addr,
    input  logic [WB_DATA_LEN-1:0] wdata,
    output logic [WB_DATA_LEN-1:0] rdata
);

    logic [WB_DATA_LEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int k = 0; k < WB_SEL_LEN; k++) begin
                if (be[k]) begin
                    mem[addr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    // Holds the last read word whenever no read beat is executing.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/wb_burst_responder.sv
// Wishbone burst slave backed by a local word array with a fixed first-beat latency.
// One request is range-checked up front; beats then advance on every edge where the master is ready.
module wb_burst_responder
    import wb_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wbd_cyc_i,
    input  logic                  wbd_stb_i,
    input  logic                  wbd_we_i,
    input  logic [ADDR_WIDTH-1:0] wbd_adr_i,
    input  logic [WB_SEL_LEN-1:0] wbd_sel_i,
    input  logic [WB_BL_LEN-1:0]  wbd_bl_i,
    input  logic                  wbd_bry_i,
    input  logic [DATA_WIDTH-1:0] wbd_dat_i,
    output logic [DATA_WIDTH-1:0] wbd_dat_o,
    output logic                  wbd_ack_o,
    output logic                  wbd_lack_o,
    output logic                  wbd_err_o,
    output wb_state_e             dbg_state
);

    // Handshake: a request is taken in IDLE when cyc&stb are high; a beat moves on an
    // edge in XFER with cyc&bry high and is answered by ack (plus lack on the last beat)
    // in the following cycle; dropping cyc in WAIT/XFER ends the burst with no further ack.

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;
    // One extra bit so a burst ending past the top of the address space is rejected.
    localparam logic [ADDR_WIDTH:0] END_LIMIT =
        {1'b0, BASE_ADDR} + ((ADDR_WIDTH+1)'(MEM_DEPTH) << 2);

    wb_state_e             state, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [WB_BL_LEN-1:0]  beats_q, beats_d;
    logic                  we_q, we_d;
    logic [WB_SEL_LEN-1:0] sel_q, sel_d;
    logic [LAT_W-1:0]      wait_q, wait_d;
    logic                  ack_q, ack_d;
    logic                  lack_q, lack_d;
    logic                  err_q, err_d;
    logic                  beat;

    logic [WB_BL_LEN-1:0]  beats_in;
    logic [ADDR_WIDTH:0]   end_addr;
    logic [IDX_W-1:0]      idx_start;
    logic                  range_ok;

    assign beats_in  = wb_beats(wbd_bl_i);
    assign end_addr  = {1'b0, wbd_adr_i} + (ADDR_WIDTH+1)'({beats_in, 2'b00});
    assign idx_start = IDX_W'((wbd_adr_i - BASE_ADDR) >> 2);
    assign range_ok  = (wbd_adr_i[1:0] == 2'b00) && (wbd_adr_i >= BASE_ADDR) &&
                       (end_addr <= END_LIMIT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            idx_q   <= '0;
            beats_q <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wait_q  <= '0;
            ack_q   <= 1'b0;
            lack_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_d;
            idx_q   <= idx_d;
            beats_q <= beats_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wait_q  <= wait_d;
            ack_q   <= ack_d;
            lack_q  <= lack_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx_q;
        beats_d = beats_q;
        we_d    = we_q;
        sel_d   = sel_q;
        wait_d  = wait_q;
        ack_d   = 1'b0;
        lack_d  = 1'b0;
        err_d   = 1'b0;
        beat    = 1'b0;
        case (state)
            IDLE: begin
                if (wbd_cyc_i && wbd_stb_i) begin
                    idx_d   = idx_start;
                    beats_d = beats_in;
                    we_d    = wbd_we_i;
                    sel_d   = wbd_sel_i;
                    wait_d  = LAT_LOAD;
                    if (!range_ok) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else if (LATENCY == 0) begin
                        state_d = XFER;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            ERR: state_d = DONE;
            WAIT: begin
                if (!wbd_cyc_i) begin
                    state_d = IDLE;
                end else if (wait_q == '0) begin
                    state_d = XFER;
                end else begin
                    wait_d = wait_q - LAT_W'(1);
                end
            end
            XFER: begin
                if (!wbd_cyc_i) begin
                    state_d = IDLE;
                end else if (wbd_bry_i) begin
                    beat    = 1'b1;
                    ack_d   = 1'b1;
                    idx_d   = idx_q + IDX_W'(1);
                    beats_d = beats_q - WB_BL_LEN'(1);
                    if (beats_q == WB_BL_LEN'(1)) begin
                        lack_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            // Wait for stb to drop so a held request cannot start a second burst.
            DONE: begin
                if (!wbd_stb_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    wb_resp_mem #(
        .DEPTH (MEM_DEPTH),
        .AW    (IDX_W)
    ) u_mem (
        .clk   (clk),
        .rstn  (rstn),
        .en    (beat),
        .we    (we_q),
        .be    (sel_q),
        .addr  (idx_q),
        .wdata (wbd_dat_i),
        .rdata (wbd_dat_o)
    );

    assign wbd_ack_o  = ack_q;
    assign wbd_lack_o = lack_q;
    assign wbd_err_o  = err_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_wb_burst_responder.sv
// Directed bench for wb_burst_responder: a driver issues bursts and queues the expected
// responses, a monitor pops and compares on every ack/lack/err it sees.
module tb_wb_burst_responder;
    import wb_pkg::*;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          LAT   = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cyc, stb, we, bry;
    logic [31:0] adr, dat_i, dat_o;
    logic [3:0]  sel;
    logic [9:0]  bl;
    logic        ack, lack, err;
    wb_state_e   dbg_state;

    int checks = 0;
    int errors = 0;

    // {kind[1:0], lack, data}: kind 01 write ack, 10 read ack, 11 error pulse
    logic [34:0] exp_q[$];
    logic [34:0] mon_e;
    logic [31:0] model [DEPTH];

    wb_burst_responder #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (DEPTH),
        .BASE_ADDR  (BASE),
        .LATENCY    (LAT)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .wbd_cyc_i  (cyc),
        .wbd_stb_i  (stb),
        .wbd_we_i   (we),
        .wbd_adr_i  (adr),
        .wbd_sel_i  (sel),
        .wbd_bl_i   (bl),
        .wbd_bry_i  (bry),
        .wbd_dat_i  (dat_i),
        .wbd_dat_o  (dat_o),
        .wbd_ack_o  (ack),
        .wbd_lack_o (lack),
        .wbd_err_o  (err),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    // Monitor: every response cycle consumes one queued expectation.
    always @(negedge clk) begin
        if (rstn && (ack || lack || err)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_response: ack=%0b lack=%0b err=%0b dat=%h, none expected",
                         ack, lack, err, dat_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e[34:33] == 2'b11) begin
                    if (!(err && !ack && !lack)) begin
                        errors++;
                        $display("FAIL err_pulse: ack=%0b lack=%0b err=%0b, required err only",
                                 ack, lack, err);
                    end
                end else if (!ack || err || lack != mon_e[32] ||
                             (mon_e[34:33] == 2'b10 && dat_o != mon_e[31:0])) begin
                    errors++;
                    $display("FAIL beat: ack=%0b lack=%0b err=%0b dat=%h, required ack=1 lack=%0b err=0 dat=%h",
                             ack, lack, err, dat_o, mon_e[32],
                             (mon_e[34:33] == 2'b10) ? mon_e[31:0] : dat_o);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] wdat(input logic [31:0] seed, input int i);
        return seed + 32'(i) * 32'h0001_0003;
    endfunction

    task automatic burst(input logic we_v, input logic [31:0] adr_v, input logic [9:0] bl_v,
                         input logic [3:0] sel_v, input logic [31:0] seed, input bit toggle,
                         input int stop_after, input bit use_reset, input bit exp_err,
                         input int hold, input int exp_first);
        int beats, n_exp, idx, got, cyc_n, first;
        bit finished;
        logic [31:0] w, m;
        beats = (bl_v == 0) ? 1 : int'(bl_v);
        n_exp = (stop_after > 0) ? stop_after : beats;
        idx   = int'((adr_v - BASE) >> 2);
        if (exp_err) begin
            exp_q.push_back({2'b11, 1'b0, 32'h0});
        end else begin
            for (int i = 0; i < n_exp; i++) begin
                if (we_v) begin
                    w = wdat(seed, i);
                    m = model[idx + i];
                    for (int k = 0; k < 4; k++) if (sel_v[k]) m[8*k +: 8] = w[8*k +: 8];
                    model[idx + i] = m;
                    exp_q.push_back({2'b01, (i == beats - 1), 32'h0});
                end else begin
                    exp_q.push_back({2'b10, (i == beats - 1), model[idx + i]});
                end
            end
        end
        cyc = 1'b1; stb = 1'b1; we = we_v; adr = adr_v; bl = bl_v; sel = sel_v;
        dat_i = wdat(seed, 0); bry = 1'b1;
        got = 0; first = 0; cyc_n = 0; finished = 1'b0;
        while (!finished && cyc_n < 300) begin
            @(posedge clk); #1;
            cyc_n++;
            if (ack) begin
                got++;
                if (first == 0) first = cyc_n;
                dat_i = wdat(seed, got);
            end
            if (err || (ack && lack) || (stop_after > 0 && got == stop_after)) finished = 1'b1;
            else if (toggle) bry = ~bry;
        end
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL burst_timeout: got %0d beats, required %0d", got, n_exp);
        end
        if (exp_first > 0) chk("first_beat_cycle", 32'(first), 32'(exp_first));
        if (stop_after > 0 && use_reset) begin
            @(negedge clk); #1;
            rstn = 1'b0;
            #1;
            chk("reset_ack_lack_err", {29'b0, ack, lack, err}, 32'h0);
            chk("reset_dat", dat_o, 32'h0);
            cyc = 1'b0; stb = 1'b0; bry = 1'b0;
            @(posedge clk); #1;
            rstn = 1'b1;
        end else if (stop_after > 0) begin
            cyc = 1'b0; stb = 1'b0; bry = 1'b0;
        end else begin
            bry = 1'b0;
            repeat (hold) begin
                @(posedge clk); #1;
            end
            if (hold > 0) chk("held_stb_state", 32'(dbg_state), 32'(DONE));
            cyc = 1'b0; stb = 1'b0;
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("idle_after_burst", 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        cyc = 0; stb = 0; we = 0; bry = 0; adr = '0; dat_i = '0; sel = '0; bl = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {29'b0, ack, lack, err}, 32'h0);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_dat", dat_o, 32'h0);
        chk("post_reset_state", 32'(dbg_state), 32'(IDLE));

        // Fill the whole array; ends exactly at the top of the window.
        burst(1, BASE, 10'd64, 4'hF, 32'hA000_0000, 0, 0, 0, 0, 0, 0);

        // Single read, first beat three edges after acceptance.
        burst(1, BASE, 10'd1, 4'hF, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
        burst(0, BASE, 10'd1, 4'h0, 32'h0, 0, 0, 0, 0, 0, LAT + 2);
        chk("single_read_dat", dat_o, 32'hDEAD_BEEF);

        // Eight-beat read with the master stalling every other cycle.
        burst(0, BASE + 32'h20, 10'd8, 4'h0, 32'h0, 1, 0, 0, 0, 0, 0);

        // Byte-masked write over all-ones.
        burst(1, BASE + 32'hA0, 10'd1, 4'hF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
        burst(1, BASE + 32'hA0, 10'd1, 4'b0101, 32'h1122_3344, 0, 0, 0, 0, 0, 0);
        burst(0, BASE + 32'hA0, 10'd1, 4'h0, 32'h0, 0, 0, 0, 0, 0, 0);
        chk("masked_readback", dat_o, 32'hFF22_FF44);

        // Rejected requests: misaligned, past the end, below the base.
        burst(1, BASE + 32'h2, 10'd1, 4'hF, 32'h0BAD_0001, 0, 0, 0, 1, 0, 0);
        burst(1, BASE + 32'(4 * DEPTH - 4), 10'd2, 4'hF, 32'h0BAD_0002, 0, 0, 0, 1, 2, 0);
        burst(0, BASE - 32'h4, 10'd1, 4'h0, 32'h0, 0, 0, 0, 1, 0, 0);
        burst(0, BASE + 32'(4 * DEPTH - 8), 10'd2, 4'h0, 32'h0, 0, 0, 0, 0, 0, 0);

        // Master drops cyc after five of sixteen write beats.
        burst(1, BASE + 32'h40, 10'd16, 4'hF, 32'h5000_0000, 0, 5, 0, 0, 0, 0);
        burst(0, BASE + 32'h40, 10'd16, 4'h0, 32'h0, 0, 0, 0, 0, 0, 0);

        // Reset lands mid-burst after three write beats.
        burst(1, BASE + 32'h80, 10'd16, 4'hF, 32'h6000_0000, 0, 3, 1, 0, 0, 0);
        burst(0, BASE + 32'h80, 10'd16, 4'h0, 32'h0, 0, 0, 0, 0, 0, 0);

        // bl=0 read with stb held, then a fresh request.
        burst(0, BASE + 32'h10, 10'd0, 4'h0, 32'h0, 0, 0, 0, 0, 5, 0);
        burst(0, BASE + 32'h10, 10'd0, 4'h0, 32'h0, 0, 0, 0, 0, 0, 0);

        // sel=0 write is acked but changes nothing.
        burst(1, BASE + 32'h14, 10'd1, 4'h0, 32'h7777_7777, 0, 0, 0, 0, 0, 0);
        burst(0, BASE + 32'h14, 10'd1, 4'h0, 32'h0, 0, 0, 0, 0, 0, 0);
        chk("sel0_readback", dat_o, wdat(32'hA000_0000, 5));

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_burst_responder.md
Name: wb_burst_responder

Overview:
- Wishbone burst slave. It is the responder end of the m2/m3 master ports that leave the hehe top: adr/dat/sel/we/cyc/stb, plus bl (burst length), bry (master burst-ready), ack, lack (last ack) and err.
- Backs a word-addressed SRAM-style array with a configurable first-beat latency.
- Uses: testbench/SoC memory model for the I$ refill (m3) and the D$/others (m2) paths, and a synthesizable scratchpad target.

Parameters:
- ADDR_WIDTH, 32, Wishbone byte-address width.
- DATA_WIDTH, 32, data width; must be 32.
- MEM_DEPTH, 1024, number of 32-bit words in the array.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- LATENCY, 2, idle cycles between request acceptance and the first beat; 0 allowed.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- wbd_cyc_i  in  1  bus cycle.
- wbd_stb_i  in  1  strobe/request.
- wbd_we_i  in  1  1=write burst, 0=read burst.
- wbd_adr_i  in  32  start byte address.
- wbd_sel_i  in  4  byte lanes for writes; ignored for reads.
- wbd_bl_i  in  10  burst beat count; 0 is treated as 1.
- wbd_bry_i  in  1  master ready: write data valid, or read data can be taken.
- wbd_dat_i  in  32  write data.
- wbd_dat_o  out  32  read data.
- wbd_ack_o  out  1  per-beat acknowledge.
- wbd_lack_o  out  1  asserted with the ack of the final beat.
- wbd_err_o  out  1  request rejected.

Behaviour:
- Reset:
  - Asynchronous, rstn=0.
  - State=IDLE; dat_o=0, ack_o=0, lack_o=0, err_o=0; beat counter and address register cleared.
  - Array contents are not reset.
  - Reset mid-burst aborts the burst immediately; no further ack.
- All outputs are registered.
- FSM states: IDLE, WAIT, XFER, ERR, DONE.
- IDLE:
  - On cyc_i&stb_i, latch adr, we, sel and beats = (bl==0)?1:bl.
  - Check: adr[1:0]==0, adr>=BASE_ADDR, and adr+4*beats <= BASE_ADDR+4*MEM_DEPTH.
  - Check fails -> ERR. Check passes -> WAIT, or XFER directly if LATENCY==0.
- ERR: err_o=1 for exactly one cycle, then -> DONE. No ack or lack is issued.
- WAIT: count down LATENCY cycles, then -> XFER.
- XFER:
  - A beat executes on a clock edge where bry_i=1.
  - Read beat: dat_o <= mem[idx], ack_o <= 1.
  - Write beat: mem[idx] byte lanes with sel[k]=1 <= dat_i, ack_o <= 1.
  - Edge with bry_i=0: ack_o <= 0, no state change (master stall).
  - After each beat: idx+1, beats-1. On the final beat also lack_o <= 1, then -> DONE.
  - ack/lack are single-cycle pulses per beat. dat_o holds its last value when ack_o=0.
- Index: idx = (adr-BASE_ADDR)>>2, incrementing by 1 per beat. No wrap is possible because the range is checked up front.
- DONE: stay until stb_i=0, then -> IDLE. This prevents a held stb from restarting a burst.
- cyc_i=0 in WAIT or XFER: abort to IDLE next cycle. No further ack; writes already completed remain in the array.
- The range check uses ADDR_WIDTH+1-bit arithmetic so an end address past 2^32 counts as out of range.
- sel=0 on a write is a legal no-op write and is still acked (the m3 path drives sel=0 on reads).

Decomposition:
- Shared package wb_pkg:
  - FSM state enum {IDLE, WAIT, XFER, ERR, DONE}.
  - WB_DATA_LEN=32, WB_BL_LEN=10, WB_SEL_LEN=4.
  - Helper function computing the beat count from bl.
- One natural sub-module, wb_resp_mem: a single-port byte-masked synchronous RAM, MEM_DEPTH x 32, read data registered. The FSM lives in the top.

Test Plan:
- Single read: preload mem[0]=32'hDEAD_BEEF, adr=BASE, bl=1, bry=1, LATENCY=2 -> ack, lack and dat_o=DEADBEEF all in the same cycle, 3 edges after acceptance; err=0.
- Burst read: bl=8 at adr=BASE+0x20 with bry toggling 1,0,1,... -> exactly 8 acks carrying mem[8..15] in order; lack only with the 8th; no ack in stall cycles.
- Masked write: write dat=32'h1122_3344, sel=4'b0101 over 32'hFFFF_FFFF, then read back -> 32'hFF22_FF44.
- Error: adr=BASE+2, or adr=BASE+4*MEM_DEPTH-4 with bl=2 -> err one cycle, no ack/lack, array unchanged; FSM returns to IDLE after stb drops.
- Abort/reset: bl=16 write, drop cyc after 5 beats -> words 0..4 written, 5..15 untouched, no further ack. Repeat with rstn=0 mid-burst -> all outputs 0 within the same cycle.
- bl=0 read with stb held high through DONE -> exactly one beat with lack; no second burst until stb goes low and high again.
